stack_sequencer: RTL and testbench

Upstream control stage for `register_stack`: accepts one instruction at a time over a valid/ready handshake, computes the write value `w` from the current top-of-stack pair `a`/`b`, and drives `stackOP`/`w` for exactly one cycle per stack update. It also bridges a 16-bit input port and output port onto the stack, tracks stack depth, and flags underflow, overflow and illegal opcodes.

---
 rtl/stack_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_stack_sequencer.sv | 450 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_sequencer.sv
// Instruction sequencer in front of register_stack: decodes opcodes, computes w from a/b, bridges I/O ports.
// Define STACK_SEQ_DEPTH_CHECK_EN to build the depth counter and underflow/overflow checks.
module stack_sequencer #(
   parameter int DEPTH = 64,
   parameter int WIDTH = 16
) (
   input  logic                    CLK,
   input  logic                    reset_n,
   input  logic [3:0]              instr,
   input  logic [WIDTH-1:0]        instr_imm,
   input  logic                    instr_valid,
   output logic                    instr_ready,
   input  logic signed [WIDTH-1:0] a,
   input  logic signed [WIDTH-1:0] b,
   output logic [2:0]              stackOP,
   output logic [WIDTH-1:0]        w,
   input  logic [WIDTH-1:0]        io_in_data,
   input  logic                    io_in_valid,
   output logic                    io_in_ready,
   output logic [WIDTH-1:0]        io_out_data,
   output logic                    io_out_valid,
   input  logic                    io_out_ready,
   output logic [6:0]              depth,
   output logic                    error,
   output logic [1:0]              err_code
);

   typedef enum logic [2:0] {
      OP_NOP  = 3'd0,
      OP_PUSH = 3'd1,
      OP_REPL = 3'd2,
      OP_POP  = 3'd3,
      OP_POP2 = 3'd4,
      OP_SWAP = 3'd5
   } op_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_IN,
      S_WAIT_OUT,
      S_LOAD,
      S_ISSUE
   } state_t;

   state_t           state;
   op_t              dec_op;
   op_t              pend_op;
   logic [WIDTH-1:0] dec_w;
   logic             dec_illegal;
   logic             under;
   logic             over;

   always_comb begin
      dec_op      = OP_NOP;
      dec_w       = '0;
      dec_illegal = 1'b0;
      case (instr)
         4'd0:  dec_op = OP_NOP;
         4'd1:  begin dec_op = OP_PUSH; dec_w = instr_imm; end
         4'd2:  begin dec_op = OP_REPL; dec_w = b + a; end
         4'd3:  begin dec_op = OP_REPL; dec_w = b - a; end
         4'd4:  begin dec_op = OP_REPL; dec_w = b & a; end
         4'd5:  begin dec_op = OP_REPL; dec_w = b | a; end
         4'd6:  dec_op = OP_POP;
         4'd7:  dec_op = OP_POP2;
         4'd8:  dec_op = OP_SWAP;
         4'd9:  begin dec_op = OP_PUSH; dec_w = a; end
         4'd10: dec_op = OP_PUSH;
         4'd11: dec_op = OP_POP;
         default: dec_illegal = 1'b1;
      endcase
   end

`ifdef STACK_SEQ_DEPTH_CHECK_EN
   localparam logic [6:0] DMAX = 7'(DEPTH);
   logic [1:0] need;

   always_comb begin
      need = 2'd0;
      case (instr)
         4'd2, 4'd3, 4'd4, 4'd5, 4'd7, 4'd8: need = 2'd2;
         4'd6, 4'd9, 4'd11:                  need = 2'd1;
         default:                            need = 2'd0;
      endcase
   end

   assign under = depth < {5'd0, need};
   assign over  = (dec_op == OP_PUSH) && (depth >= DMAX);

   // Depth moves on the edge that retires the ISSUE cycle, i.e. together with the stack.
   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         depth <= '0;
      end else if (state == S_ISSUE) begin
         case (stackOP)
            OP_PUSH:          depth <= depth + 7'd1;
            OP_REPL, OP_POP:  depth <= depth - 7'd1;
            OP_POP2:          depth <= depth - 7'd2;
            default:          depth <= depth;
         endcase
      end
   end
`else
   assign under = 1'b0;
   assign over  = 1'b0;
   assign depth = '0;
`endif

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         state        <= S_IDLE;
         instr_ready  <= 1'b1;
         stackOP      <= OP_NOP;
         w            <= '0;
         io_in_ready  <= 1'b0;
         io_out_valid <= 1'b0;
         io_out_data  <= '0;
         error        <= 1'b0;
         err_code     <= 2'd0;
         pend_op      <= OP_NOP;
      end else begin
         case (state)
            S_IDLE: begin
               if (instr_valid) begin
                  if (dec_illegal || under || over) begin
                     if (!error) begin
                        error    <= 1'b1;
                        err_code <= dec_illegal ? 2'd3 : (under ? 2'd1 : 2'd2);
                     end
                  end else if (instr == 4'd10) begin
                     instr_ready <= 1'b0;
                     io_in_ready <= 1'b1;
                     state       <= S_WAIT_IN;
                  end else if (instr == 4'd11) begin
                     instr_ready  <= 1'b0;
                     io_out_valid <= 1'b1;
                     io_out_data  <= a;
                     state        <= S_WAIT_OUT;
                  end else if (dec_op != OP_NOP) begin
                     instr_ready <= 1'b0;
                     stackOP     <= dec_op;
                     w           <= dec_w;
                     state       <= S_ISSUE;
                  end
               end
            end
            S_WAIT_IN: begin
               if (io_in_valid) begin
                  io_in_ready <= 1'b0;
                  w           <= io_in_data;
                  pend_op     <= OP_PUSH;
                  state       <= S_LOAD;
               end
            end
            S_WAIT_OUT: begin
               if (io_out_ready) begin
                  io_out_valid <= 1'b0;
                  pend_op      <= OP_POP;
                  state        <= S_LOAD;
               end
            end
            // I/O ops take one extra cycle so stackOP still pulses from a registered source.
            S_LOAD: begin
               stackOP <= pend_op;
               state   <= S_ISSUE;
            end
            S_ISSUE: begin
               stackOP     <= OP_NOP;
               instr_ready <= 1'b1;
               state       <= S_IDLE;
            end
            default: begin
               stackOP     <= OP_NOP;
               instr_ready <= 1'b1;
               state       <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_stack_sequencer.sv
// Self-checking bench for stack_sequencer with a behavioural stack model feeding a/b.
module tb_stack_sequencer;
   localparam int DEPTH = 64;
   localparam int WIDTH = 16;

   logic             CLK = 1'b0;
   logic             reset_n;
   logic [3:0]       instr;
   logic [WIDTH-1:0] instr_imm;
   logic             instr_valid;
   logic             instr_ready;
   logic [WIDTH-1:0] a, b;
   logic [2:0]       stackOP;
   logic [WIDTH-1:0] w;
   logic [WIDTH-1:0] io_in_data;
   logic             io_in_valid;
   logic             io_in_ready;
   logic [WIDTH-1:0] io_out_data;
   logic             io_out_valid;
   logic             io_out_ready;
   logic [6:0]       depth;
   logic             error;
   logic [1:0]       err_code;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [2:0]       op;
      logic [WIDTH-1:0] w;
      bit               chkw;
   } exp_t;
   exp_t sbq[$];

   time last_acc = 0;
   time acc_gap  = 0;

   stack_sequencer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .CLK(CLK), .reset_n(reset_n),
      .instr(instr), .instr_imm(instr_imm), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .a(a), .b(b), .stackOP(stackOP), .w(w),
      .io_in_data(io_in_data), .io_in_valid(io_in_valid), .io_in_ready(io_in_ready),
      .io_out_data(io_out_data), .io_out_valid(io_out_valid), .io_out_ready(io_out_ready),
      .depth(depth), .error(error), .err_code(err_code)
   );

   always #5 CLK = ~CLK;

   // Behavioural register_stack: index 0 is top; pushes past capacity drop the bottom.
   logic [WIDTH-1:0] mem [0:DEPTH-1];
   assign a = mem[0];
   assign b = mem[1];

   always @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         case (stackOP)
            3'd1: begin
               mem[0] <= w;
               for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
            end
            3'd2: begin
               mem[0] <= w;
               for (int i = 1; i < DEPTH-1; i++) mem[i] <= mem[i+1];
               mem[DEPTH-1] <= '0;
            end
            3'd3: begin
               for (int i = 0; i < DEPTH-1; i++) mem[i] <= mem[i+1];
               mem[DEPTH-1] <= '0;
            end
            3'd4: begin
               for (int i = 0; i < DEPTH-2; i++) mem[i] <= mem[i+2];
               mem[DEPTH-2] <= '0;
               mem[DEPTH-1] <= '0;
            end
            3'd5: begin
               mem[0] <= mem[1];
               mem[1] <= mem[0];
            end
            default: ;
         endcase
      end
   end

   // Scoreboard: every non-zero stackOP cycle must match the next expected issue.
   always @(negedge CLK) begin
      if (reset_n === 1'b1 && stackOP !== 3'd0) begin
         checks++;
         if (sbq.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected got op=%0d w=%h want no stack op", stackOP, w);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            if (stackOP !== e.op || (e.chkw && w !== e.w)) begin
               errors++;
               $display("FAIL sb_issue got op=%0d w=%h want op=%0d w=%h", stackOP, w, e.op, e.w);
            end
         end
      end
   end

   function automatic logic [6:0] edepth(input int n);
`ifdef STACK_SEQ_DEPTH_CHECK_EN
      return 7'(n);
`else
      return 7'(n * 0);
`endif
   endfunction

   task automatic expect_op(input logic [2:0] op, input logic [WIDTH-1:0] wv, input bit chkw);
      exp_t e;
      e.op = op; e.w = wv; e.chkw = chkw;
      sbq.push_back(e);
   endtask

   task automatic send(input logic [3:0] op, input logic [WIDTH-1:0] imm);
      int n;
      n = 0;
      @(negedge CLK);
      while (instr_ready !== 1'b1 && n < 40) begin @(negedge CLK); n++; end
      checks++;
      if (instr_ready !== 1'b1) begin
         errors++;
         $display("FAIL send_ready op=%0d got instr_ready=%b want 1", op, instr_ready);
      end
      instr = op; instr_imm = imm; instr_valid = 1'b1;
      @(posedge CLK);
      acc_gap  = $time - last_acc;
      last_acc = $time;
      #1 instr_valid = 1'b0;
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      @(negedge CLK);
      while (instr_ready !== 1'b1 && n < 40) begin @(negedge CLK); n++; end
      checks++;
      if (instr_ready !== 1'b1) begin
         errors++;
         $display("FAIL wait_ready got instr_ready=%b want 1", instr_ready);
      end
   endtask

   task automatic do_reset();
      @(negedge CLK);
      reset_n = 1'b0;
      repeat (2) @(negedge CLK);
      sbq.delete();
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (2) @(negedge CLK);
      checks++;
      if ({instr_ready, stackOP, io_in_ready, io_out_valid, error, err_code} !== {1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 2'd0}) begin
         errors++;
         $display("FAIL reset_ctrl got rdy=%b op=%0d inr=%b outv=%b err=%b code=%0d want 1 0 0 0 0 0",
                  instr_ready, stackOP, io_in_ready, io_out_valid, error, err_code);
      end
      checks++;
      if ({w, io_out_data, depth} !== '0) begin
         errors++;
         $display("FAIL reset_data got w=%h out=%h depth=%0d want 0 0 0", w, io_out_data, depth);
      end
      reset_n = 1'b1;
   endtask

   task automatic test_alu();
      expect_op(3'd1, 16'd1, 1'b1);
      send(4'd1, 16'd1);
      expect_op(3'd1, 16'd4, 1'b1);
      send(4'd1, 16'd4);
      expect_op(3'd2, 16'd5, 1'b1);
      send(4'd2, '0);
      wait_ready();
      checks++;
      if (a !== 16'd5 || depth !== edepth(1)) begin
         errors++;
         $display("FAIL add_result got a=%h depth=%0d want a=0005 depth=%0d", a, depth, edepth(1));
      end
   endtask

   task automatic test_ops();
      expect_op(3'd3, '0, 1'b0);
      send(4'd6, '0);
      expect_op(3'd1, 16'd2, 1'b1);
      send(4'd1, 16'd2);
      expect_op(3'd1, 16'd7, 1'b1);
      send(4'd1, 16'd7);
      expect_op(3'd2, 16'hFFFB, 1'b1);
      send(4'd3, '0);
      wait_ready();
      checks++;
      if (a !== 16'hFFFB) begin
         errors++;
         $display("FAIL sub_wrap got a=%h want fffb", a);
      end
      expect_op(3'd1, 16'hFFFB, 1'b1);
      send(4'd9, '0);
      wait_ready();
      checks++;
      if (depth !== edepth(2) || b !== 16'hFFFB) begin
         errors++;
         $display("FAIL dup got depth=%0d b=%h want depth=%0d b=fffb", depth, b, edepth(2));
      end
      expect_op(3'd5, '0, 1'b0);
      send(4'd8, '0);
      wait_ready();
      checks++;
      if (a !== 16'hFFFB) begin
         errors++;
         $display("FAIL swap got a=%h want fffb", a);
      end
      expect_op(3'd1, 16'h00F0, 1'b1);
      send(4'd1, 16'h00F0);
      expect_op(3'd2, 16'h00F0, 1'b1);
      send(4'd4, '0);
      expect_op(3'd2, 16'hFFFB, 1'b1);
      send(4'd5, '0);
      expect_op(3'd1, 16'h1111, 1'b1);
      send(4'd1, 16'h1111);
      expect_op(3'd4, '0, 1'b0);
      send(4'd7, '0);
      wait_ready();
      checks++;
      if (depth !== edepth(0) || a !== 16'h0000) begin
         errors++;
         $display("FAIL drop2 got depth=%0d a=%h want depth=0 a=0000", depth, a);
      end
   endtask

   task automatic test_in_out();
      bit ok;
      expect_op(3'd1, 16'h1234, 1'b1);
      send(4'd10, '0);
      ok = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         if (io_in_ready !== 1'b1) ok = 1'b0;
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL in_ready_hold got io_in_ready=%b want 1 while waiting", io_in_ready);
      end
      io_in_data = 16'h1234; io_in_valid = 1'b1;
      @(posedge CLK);
      #1 io_in_valid = 1'b0; io_in_data = '0;
      @(negedge CLK);
      checks++;
      if (stackOP !== 3'd0 || io_in_ready !== 1'b0) begin
         errors++;
         $display("FAIL in_after_hs got op=%0d in_ready=%b want 0 0", stackOP, io_in_ready);
      end
      @(negedge CLK);
      checks++;
      if (stackOP !== 3'd1) begin
         errors++;
         $display("FAIL in_issue got op=%0d want 1", stackOP);
      end
      wait_ready();
      checks++;
      if (a !== 16'h1234 || depth !== edepth(1)) begin
         errors++;
         $display("FAIL in_result got a=%h depth=%0d want 1234 %0d", a, depth, edepth(1));
      end

      expect_op(3'd3, '0, 1'b0);
      send(4'd11, '0);
      ok = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         if (io_out_valid !== 1'b1 || io_out_data !== 16'h1234 || stackOP !== 3'd0) ok = 1'b0;
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL out_hold got valid=%b data=%h want 1 1234", io_out_valid, io_out_data);
      end
      io_out_ready = 1'b1;
      @(posedge CLK);
      #1 io_out_ready = 1'b0;
      wait_ready();
      checks++;
      if (depth !== edepth(0) || a !== 16'h0000 || io_out_valid !== 1'b0) begin
         errors++;
         $display("FAIL out_result got depth=%0d a=%h valid=%b want 0 0000 0", depth, a, io_out_valid);
      end
   endtask

   task automatic test_errors();
`ifdef STACK_SEQ_DEPTH_CHECK_EN
      send(4'd2, '0);
      wait_ready();
      checks++;
      if (error !== 1'b1 || err_code !== 2'd1) begin
         errors++;
         $display("FAIL underflow got error=%b code=%0d want 1 1", error, err_code);
      end
      send(4'd13, '0);
      wait_ready();
      checks++;
      if (error !== 1'b1 || err_code !== 2'd1) begin
         errors++;
         $display("FAIL first_err_kept got error=%b code=%0d want 1 1", error, err_code);
      end
`else
      expect_op(3'd2, 16'h0000, 1'b1);
      send(4'd2, '0);
      wait_ready();
      checks++;
      if (error !== 1'b0 || err_code !== 2'd0) begin
         errors++;
         $display("FAIL no_underflow got error=%b code=%0d want 0 0", error, err_code);
      end
      send(4'd13, '0);
      wait_ready();
      checks++;
      if (error !== 1'b1 || err_code !== 2'd3) begin
         errors++;
         $display("FAIL illegal got error=%b code=%0d want 1 3", error, err_code);
      end
`endif
      expect_op(3'd1, 16'd9, 1'b1);
      send(4'd1, 16'd9);
      wait_ready();
      checks++;
      if (a !== 16'd9 || error !== 1'b1) begin
         errors++;
         $display("FAIL after_err got a=%h error=%b want 0009 1", a, error);
      end
   endtask

   task automatic test_back_to_back_overflow();
      int bad;
      bad = 0;
      for (int i = 0; i < DEPTH; i++) begin
         expect_op(3'd1, 16'(i + 1), 1'b1);
         send(4'd1, 16'(i + 1));
         if (i > 0 && acc_gap != 20) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL throughput got %0d slow accepts want 0 (gap 2 cycles)", bad);
      end
      wait_ready();
      checks++;
      if (depth !== edepth(DEPTH) || a !== 16'(DEPTH)) begin
         errors++;
         $display("FAIL full got depth=%0d a=%h want %0d %h", depth, a, edepth(DEPTH), 16'(DEPTH));
      end
`ifdef STACK_SEQ_DEPTH_CHECK_EN
      send(4'd1, 16'h0077);
      wait_ready();
      checks++;
      if (error !== 1'b1 || err_code !== 2'd2 || depth !== 7'd64 || a !== 16'(DEPTH)) begin
         errors++;
         $display("FAIL overflow got error=%b code=%0d depth=%0d a=%h want 1 2 64 0040", error, err_code, depth, a);
      end
`else
      expect_op(3'd1, 16'h0077, 1'b1);
      send(4'd1, 16'h0077);
      wait_ready();
      checks++;
      if (error !== 1'b0 || a !== 16'h0077) begin
         errors++;
         $display("FAIL push_past_full got error=%b a=%h want 0 0077", error, a);
      end
`endif
      for (int i = 0; i < DEPTH; i++) begin
         expect_op(3'd3, '0, 1'b0);
         send(4'd6, '0);
      end
      wait_ready();
      checks++;
      if (a !== 16'h0000 || depth !== edepth(0)) begin
         errors++;
         $display("FAIL drained got a=%h depth=%0d want 0000 0", a, depth);
      end
   endtask

   task automatic test_reset_mid();
      int n;
      expect_op(3'd1, 16'hABCD, 1'b1);
      send(4'd1, 16'hABCD);
      expect_op(3'd3, '0, 1'b0);
      send(4'd11, '0);
      n = 0;
      @(negedge CLK);
      while (io_out_valid !== 1'b1 && n < 20) begin @(negedge CLK); n++; end
      checks++;
      if (io_out_valid !== 1'b1 || io_out_data !== 16'hABCD) begin
         errors++;
         $display("FAIL mid_out got valid=%b data=%h want 1 abcd", io_out_valid, io_out_data);
      end
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if ({io_out_valid, io_in_ready, instr_ready, stackOP, w, io_out_data, depth, error} !==
          {1'b0, 1'b0, 1'b1, 3'd0, 16'h0, 16'h0, 7'd0, 1'b0}) begin
         errors++;
         $display("FAIL async_reset got outv=%b rdy=%b op=%0d w=%h out=%h depth=%0d want 0 1 0 0 0 0",
                  io_out_valid, instr_ready, stackOP, w, io_out_data, depth);
      end
      sbq.delete();
      @(negedge CLK);
      reset_n = 1'b1;
      expect_op(3'd1, 16'd5, 1'b1);
      send(4'd1, 16'd5);
      wait_ready();
      checks++;
      if (a !== 16'd5 || io_out_valid !== 1'b0 || depth !== edepth(1)) begin
         errors++;
         $display("FAIL post_reset got a=%h outv=%b depth=%0d want 0005 0 %0d", a, io_out_valid, depth, edepth(1));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_n = 1'b0; instr = '0; instr_imm = '0; instr_valid = 1'b0;
      io_in_data = '0; io_in_valid = 1'b0; io_out_ready = 1'b0;
      test_reset();
      test_alu();
      test_ops();
      test_in_out();
      test_errors();
      do_reset();
      test_back_to_back_overflow();
      test_reset_mid();
      repeat (3) @(negedge CLK);
      checks++;
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL sb_leftover got %0d pending want 0", sbq.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
